thread_scheduler: RTL and testbench

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/thread_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_thread_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// thread_scheduler
//
// Dispatches tagged jobs onto a fixed array of thread slots and reports their
// completion. Every slot runs its own IDLE -> LAUNCH -> RUN -> DONE lifecycle.
// New jobs go to the first idle slot at or after a dispatch round-robin
// pointer. Finished slots are reported one at a time through a completion
// handshake, chosen by a separate round-robin pointer.
//
// Optional feature: define THREAD_SCHED_WATCHDOG_EN to add a per-slot watchdog.
// With it, a slot that stays in LAUNCH/RUN for 2^WDOG_WIDTH-1 cycles without
// thread_done is forced to DONE and its completion carries cmpl_error=1.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   en                dispatch enable (blocks new jobs only)
//   job_valid/job_id/job_ready                       job request handshake
//   start_thread      registered one-cycle launch pulse, one-hot
//   thread_busy, thread_done                         per-thread status inputs
//   cmpl_valid/cmpl_ready/cmpl_id/cmpl_thread/cmpl_error  completion handshake
//   active_count      registered count of slots not in IDLE

module thread_scheduler #(
    parameter int unsigned NUM_THREADS      = 8,
    parameter int unsigned THREAD_IDX_WIDTH = 3,
    parameter int unsigned JOB_ID_WIDTH     = 8,
    parameter int unsigned WDOG_WIDTH       = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        job_valid,
    input  logic [JOB_ID_WIDTH-1:0]     job_id,
    output logic                        job_ready,
    output logic [NUM_THREADS-1:0]      start_thread,
    input  logic [NUM_THREADS-1:0]      thread_busy,
    input  logic [NUM_THREADS-1:0]      thread_done,
    output logic                        cmpl_valid,
    input  logic                        cmpl_ready,
    output logic [JOB_ID_WIDTH-1:0]     cmpl_id,
    output logic [THREAD_IDX_WIDTH-1:0] cmpl_thread,
    output logic                        cmpl_error,
    output logic [THREAD_IDX_WIDTH:0]   active_count
);

    typedef enum logic [1:0] {StIdle, StLaunch, StRun, StDone} slot_state_e;

    slot_state_e                 state_q [NUM_THREADS];
    slot_state_e                 state_d [NUM_THREADS];
    logic [JOB_ID_WIDTH-1:0]     job_id_q [NUM_THREADS];
    logic [THREAD_IDX_WIDTH-1:0] disp_ptr_q, disp_ptr_d;
    logic [THREAD_IDX_WIDTH-1:0] cmpl_ptr_q, cmpl_ptr_d;
    logic [NUM_THREADS-1:0]      start_q;
    logic [THREAD_IDX_WIDTH:0]   active_q, active_d;
    logic                        cmpl_lock_q;
    logic [THREAD_IDX_WIDTH-1:0] cmpl_slot_q;

    logic [NUM_THREADS-1:0]      idle_vec, done_vec, wdog_expire;
    logic [NUM_THREADS-1:0]      disp_onehot, cmpl_onehot;
    logic [THREAD_IDX_WIDTH-1:0] disp_slot, cmpl_rr_slot, cmpl_sel;
    logic                        dispatch, cmpl_fire;

    // Slot status vectors and the two round-robin searches.
    always_comb begin
        logic [THREAD_IDX_WIDTH-1:0] idx;
        logic                        disp_hit;
        logic                        cmpl_hit;
        idx          = '0;
        disp_hit     = 1'b0;
        cmpl_hit     = 1'b0;
        disp_slot    = disp_ptr_q;
        cmpl_rr_slot = cmpl_ptr_q;
        idle_vec     = '0;
        done_vec     = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            idle_vec[t] = (state_q[t] == StIdle);
            done_vec[t] = (state_q[t] == StDone);
        end
        for (int i = 0; i < NUM_THREADS; i++) begin
            idx = THREAD_IDX_WIDTH'((int'(disp_ptr_q) + i) % NUM_THREADS);
            if (!disp_hit && idle_vec[idx]) begin
                disp_hit  = 1'b1;
                disp_slot = idx;
            end
            idx = THREAD_IDX_WIDTH'((int'(cmpl_ptr_q) + i) % NUM_THREADS);
            if (!cmpl_hit && done_vec[idx]) begin
                cmpl_hit     = 1'b1;
                cmpl_rr_slot = idx;
            end
        end
    end

    assign job_ready  = en && (|idle_vec);
    assign dispatch   = job_valid && job_ready;
    assign cmpl_valid = |done_vec;
    assign cmpl_fire  = cmpl_valid && cmpl_ready;
    // Once a completion is presented and stalled, keep presenting the same
    // slot even if an earlier slot (in pointer order) finishes meanwhile.
    assign cmpl_sel   = cmpl_lock_q ? cmpl_slot_q : cmpl_rr_slot;

    assign disp_onehot = dispatch  ? (NUM_THREADS'(1) << disp_slot) : '0;
    assign cmpl_onehot = cmpl_fire ? (NUM_THREADS'(1) << cmpl_sel)  : '0;

    // Per-slot next state, pointers and occupancy count.
    always_comb begin
        active_d = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            state_d[t] = state_q[t];
            case (state_q[t])
                StIdle:   if (disp_onehot[t]) state_d[t] = StLaunch;
                StLaunch: begin
                    // done (or watchdog) wins over busy
                    if (thread_done[t] || wdog_expire[t]) state_d[t] = StDone;
                    else if (thread_busy[t])              state_d[t] = StRun;
                end
                StRun:    if (thread_done[t] || wdog_expire[t]) state_d[t] = StDone;
                StDone:   if (cmpl_onehot[t]) state_d[t] = StIdle;
                default:  state_d[t] = StIdle;
            endcase
            if (state_d[t] != StIdle) active_d = active_d + 1'b1;
        end

        disp_ptr_d = disp_ptr_q;
        if (dispatch) begin
            disp_ptr_d = (disp_slot == THREAD_IDX_WIDTH'(NUM_THREADS - 1)) ? '0 : disp_slot + 1'b1;
        end
        cmpl_ptr_d = cmpl_ptr_q;
        if (cmpl_fire) begin
            cmpl_ptr_d = (cmpl_sel == THREAD_IDX_WIDTH'(NUM_THREADS - 1)) ? '0 : cmpl_sel + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t]  <= StIdle;
                job_id_q[t] <= '0;
            end
            disp_ptr_q  <= '0;
            cmpl_ptr_q  <= '0;
            start_q     <= '0;
            active_q    <= '0;
            cmpl_lock_q <= 1'b0;
            cmpl_slot_q <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= state_d[t];
                if (disp_onehot[t]) job_id_q[t] <= job_id;
            end
            disp_ptr_q  <= disp_ptr_d;
            cmpl_ptr_q  <= cmpl_ptr_d;
            start_q     <= disp_onehot;
            active_q    <= active_d;
            cmpl_lock_q <= cmpl_valid && !cmpl_ready;
            cmpl_slot_q <= cmpl_sel;
        end
    end

    assign start_thread = start_q;
    assign active_count = active_q;
    assign cmpl_id      = cmpl_valid ? job_id_q[cmpl_sel] : '0;
    assign cmpl_thread  = cmpl_valid ? cmpl_sel : '0;

`ifdef THREAD_SCHED_WATCHDOG_EN
    // Expiry fires in the cycle the counter holds 2^WDOG_WIDTH-2, so the slot
    // reaches DONE after exactly 2^WDOG_WIDTH-1 cycles in LAUNCH/RUN.
    localparam logic [WDOG_WIDTH-1:0] WdogLast = {{(WDOG_WIDTH-1){1'b1}}, 1'b0};

    logic [WDOG_WIDTH-1:0]  wdog_cnt_q [NUM_THREADS];
    logic [NUM_THREADS-1:0] wdog_err_q;

    always_comb begin
        wdog_expire = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            wdog_expire[t] = (state_q[t] == StLaunch || state_q[t] == StRun) &&
                             !thread_done[t] && (wdog_cnt_q[t] == WdogLast);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) wdog_cnt_q[t] <= '0;
            wdog_err_q <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (disp_onehot[t]) begin
                    wdog_cnt_q[t] <= '0;
                    wdog_err_q[t] <= 1'b0;
                end else if (state_q[t] == StLaunch || state_q[t] == StRun) begin
                    wdog_cnt_q[t] <= wdog_cnt_q[t] + 1'b1;
                    if (wdog_expire[t]) wdog_err_q[t] <= 1'b1;
                end
            end
        end
    end

    assign cmpl_error = cmpl_valid && wdog_err_q[cmpl_sel];
`else
    // Keeps WDOG_WIDTH referenced when the watchdog is compiled out.
    logic [WDOG_WIDTH-1:0] unused_wdog_width;
    assign unused_wdog_width = '0;
    assign wdog_expire       = '0;
    assign cmpl_error        = 1'b0;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Testbench for thread_scheduler: table-driven directed vectors plus
// hand-written reset and watchdog sequences.

module tb_thread_scheduler;

    localparam int unsigned NT = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned JW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          en, job_valid, job_ready;
    logic [JW-1:0] job_id;
    logic [NT-1:0] start_thread, thread_busy, thread_done;
    logic          cmpl_valid, cmpl_ready, cmpl_error;
    logic [JW-1:0] cmpl_id;
    logic [IW-1:0] cmpl_thread;
    logic [IW:0]   active_count;

    int checks = 0;
    int errors = 0;

    thread_scheduler #(
        .NUM_THREADS(NT), .THREAD_IDX_WIDTH(IW), .JOB_ID_WIDTH(JW), .WDOG_WIDTH(10)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .job_valid(job_valid), .job_id(job_id),
        .job_ready(job_ready), .start_thread(start_thread), .thread_busy(thread_busy),
        .thread_done(thread_done), .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
        .cmpl_id(cmpl_id), .cmpl_thread(cmpl_thread), .cmpl_error(cmpl_error),
        .active_count(active_count)
    );

`ifdef THREAD_SCHED_WATCHDOG_EN
    logic          w_en, w_job_valid, w_job_ready;
    logic [JW-1:0] w_job_id, w_cmpl_id;
    logic [NT-1:0] w_start_thread, w_thread_busy, w_thread_done;
    logic          w_cmpl_valid, w_cmpl_ready, w_cmpl_error;
    logic [IW-1:0] w_cmpl_thread;
    logic [IW:0]   w_active_count;

    thread_scheduler #(
        .NUM_THREADS(NT), .THREAD_IDX_WIDTH(IW), .JOB_ID_WIDTH(JW), .WDOG_WIDTH(4)
    ) dut_wdog (
        .clk(clk), .reset(reset), .en(w_en), .job_valid(w_job_valid), .job_id(w_job_id),
        .job_ready(w_job_ready), .start_thread(w_start_thread),
        .thread_busy(w_thread_busy), .thread_done(w_thread_done),
        .cmpl_valid(w_cmpl_valid), .cmpl_ready(w_cmpl_ready), .cmpl_id(w_cmpl_id),
        .cmpl_thread(w_cmpl_thread), .cmpl_error(w_cmpl_error),
        .active_count(w_active_count)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_before;
        logic          en, jv;
        logic [JW-1:0] id;
        logic [NT-1:0] busy, done;
        logic          cr;
        logic          exp_jr, exp_cv;
        logic [JW-1:0] exp_cid;
        logic [IW-1:0] exp_cthr;
        logic [NT-1:0] exp_start;
        logic [IW:0]   exp_active;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input int rb, input int e, input int jv, input int id,
                               input int busy, input int done, input int cr,
                               input int jr, input int cv, input int cid, input int thr,
                               input int st, input int act);
        vec_t r;
        r.rst_before = 1'(rb);
        r.en         = 1'(e);
        r.jv         = 1'(jv);
        r.id         = JW'(id);
        r.busy       = NT'(busy);
        r.done       = NT'(done);
        r.cr         = 1'(cr);
        r.exp_jr     = 1'(jr);
        r.exp_cv     = 1'(cv);
        r.exp_cid    = JW'(cid);
        r.exp_cthr   = IW'(thr);
        r.exp_start  = NT'(st);
        r.exp_active = (IW+1)'(act);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        en          = 1'b1;
        job_valid   = 1'b0;
        job_id      = '0;
        thread_busy = '0;
        thread_done = '0;
        cmpl_ready  = 1'b0;
`ifdef THREAD_SCHED_WATCHDOG_EN
        w_en          = 1'b1;
        w_job_valid   = 1'b0;
        w_job_id      = '0;
        w_thread_busy = '0;
        w_thread_done = '0;
        w_cmpl_ready  = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
    endtask

    // Combinational outputs are checked with the row's inputs applied; the
    // registered outputs are checked just after the following clock edge.
    task automatic apply_vec(input int n, input vec_t r);
        if (r.rst_before) reset_dut();
        en          = r.en;
        job_valid   = r.jv;
        job_id      = r.id;
        thread_busy = r.busy;
        thread_done = r.done;
        cmpl_ready  = r.cr;
        #1;
        chk($sformatf("vec%0d job_ready", n), 32'(job_ready), 32'(r.exp_jr));
        chk($sformatf("vec%0d cmpl_valid", n), 32'(cmpl_valid), 32'(r.exp_cv));
        chk($sformatf("vec%0d cmpl_id", n), 32'(cmpl_id), 32'(r.exp_cid));
        chk($sformatf("vec%0d cmpl_thread", n), 32'(cmpl_thread), 32'(r.exp_cthr));
        chk($sformatf("vec%0d cmpl_error", n), 32'(cmpl_error), 32'(0));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d start_thread", n), 32'(start_thread), 32'(r.exp_start));
        chk($sformatf("vec%0d active_count", n), 32'(active_count), 32'(r.exp_active));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_dut();
        chk("reset start_thread", 32'(start_thread), 32'(0));
        chk("reset active_count", 32'(active_count), 32'(0));
        chk("reset cmpl_valid", 32'(cmpl_valid), 32'(0));
        chk("reset cmpl_id", 32'(cmpl_id), 32'(0));
        chk("reset cmpl_thread", 32'(cmpl_thread), 32'(0));
        chk("reset cmpl_error", 32'(cmpl_error), 32'(0));
        chk("reset job_ready", 32'(job_ready), 32'(1));

        //                 rb en jv id     busy  done  cr  jr cv cid    thr st     act
        // Single job: launch, busy, done, stalled then accepted completion.
        vecs.push_back(v(1, 1, 1, 'h11, 'h00, 'h00, 0, 1, 0, 'h00, 0, 'h01, 1));
        vecs.push_back(v(0, 1, 0, 'h00, 'h01, 'h00, 0, 1, 0, 'h00, 0, 'h00, 1));
        vecs.push_back(v(0, 1, 0, 'h00, 'h01, 'h01, 0, 1, 0, 'h00, 0, 'h00, 1));
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h00, 0, 1, 1, 'h11, 0, 'h00, 1));
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h00, 1, 1, 1, 'h11, 0, 'h00, 0));
        // Nine back-to-back jobs from reset: eight slots fill, ninth is refused.
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(v((i == 0) ? 1 : 0, 1, 1, 'h20 + i, 0, 0, 0, 1, 0, 0, 0,
                             1 << i, i + 1));
        end
        vecs.push_back(v(0, 1, 1, 'h28, 'h00, 'h00, 0, 0, 0, 'h00, 0, 'h00, 8));
        // Threads 2 and 5 finish together; stall 3 cycles, then drain in order.
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h24, 0, 0, 0, 'h00, 0, 'h00, 8));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h00, 0, 0, 1, 'h22, 2, 'h00, 8));
        end
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h00, 1, 0, 1, 'h22, 2, 'h00, 7));
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h00, 1, 1, 1, 'h25, 5, 'h00, 6));
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h00, 0, 1, 0, 'h00, 0, 'h00, 6));
        // en=0 blocks dispatch but a done still completes.
        vecs.push_back(v(0, 0, 1, 'h33, 'h00, 'h01, 0, 0, 0, 'h00, 0, 'h00, 6));
        vecs.push_back(v(0, 0, 1, 'h33, 'h00, 'h00, 0, 0, 1, 'h20, 0, 'h00, 6));
        // Dispatch and completion in one cycle; slot 0 skipped while in DONE.
        vecs.push_back(v(0, 1, 1, 'h44, 'h00, 'h00, 1, 1, 1, 'h20, 0, 'h04, 6));
        vecs.push_back(v(0, 1, 1, 'h55, 'h00, 'h00, 0, 1, 0, 'h00, 0, 'h20, 7));
        vecs.push_back(v(0, 1, 1, 'h66, 'h00, 'h00, 0, 1, 0, 'h00, 0, 'h01, 8));
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h04, 0, 0, 0, 'h00, 0, 'h00, 8));
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h00, 1, 0, 1, 'h44, 2, 'h00, 7));
        // done on an idle slot is ignored.
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h04, 0, 1, 0, 'h00, 0, 'h00, 7));
        vecs.push_back(v(0, 1, 0, 'h00, 'h00, 'h00, 0, 1, 0, 'h00, 0, 'h00, 7));

        foreach (vecs[n]) apply_vec(n, vecs[n]);

        // Reset with four threads running drops everything.
        reset_dut();
        cmpl_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            job_valid = 1'b1;
            job_id    = JW'('h70 + i);
            step();
        end
        job_valid   = 1'b0;
        thread_busy = 'h0F;
        step();
        chk("run4 active_count", 32'(active_count), 32'(4));
        reset     = 1'b1;
        job_valid = 1'b1;
        step();
        chk("midrst start_thread", 32'(start_thread), 32'(0));
        chk("midrst active_count", 32'(active_count), 32'(0));
        chk("midrst cmpl_valid", 32'(cmpl_valid), 32'(0));
        chk("midrst cmpl_id", 32'(cmpl_id), 32'(0));
        chk("midrst cmpl_thread", 32'(cmpl_thread), 32'(0));
        chk("midrst cmpl_error", 32'(cmpl_error), 32'(0));
        reset       = 1'b0;
        job_valid   = 1'b0;
        thread_busy = '0;
        thread_done = 'h0F;
        step();
        chk("postrst done cmpl_valid", 32'(cmpl_valid), 32'(0));
        chk("postrst done active_count", 32'(active_count), 32'(0));
        thread_done = '0;
        step();
        chk("postrst idle cmpl_valid", 32'(cmpl_valid), 32'(0));
        chk("postrst idle start_thread", 32'(start_thread), 32'(0));

`ifdef THREAD_SCHED_WATCHDOG_EN
        // Watchdog with WDOG_WIDTH=4: forced DONE after 15 cycles, error set.
        reset_dut();
        w_job_valid = 1'b1;
        w_job_id    = 'h5A;
        step();
        w_job_valid = 1'b0;
        chk("wdog start_thread", 32'(w_start_thread), 32'(1));
        repeat (14) step();
        chk("wdog early cmpl_valid", 32'(w_cmpl_valid), 32'(0));
        step();
        chk("wdog cmpl_valid", 32'(w_cmpl_valid), 32'(1));
        chk("wdog cmpl_error", 32'(w_cmpl_error), 32'(1));
        chk("wdog cmpl_id", 32'(w_cmpl_id), 32'('h5A));
        chk("wdog cmpl_thread", 32'(w_cmpl_thread), 32'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
